// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared sizing, config record and length-mask helper for the sequence detector
package seq_det_pkg;
  localparam int MAX_LEN = 8;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic overlap;
  } cfg_t;
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    return ~({MAX_LEN{1'b1}} << len);
  endfunction
endpackage

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: data, config and status bundle of the programmable sequence detector
interface seq_detector_prog_if import seq_det_pkg::*; #(
  parameter int CNT_W = 16
) ();
  logic din;
  logic din_valid;
  logic cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic cfg_overlap;
  logic cnt_clr;
  logic dout;
  logic [CNT_W-1:0] match_count;
  logic cfg_err;
  modport master (
    output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input dout, match_count, cfg_err
  );
  modport slave (
    input din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output dout, match_count, cfg_err
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter whose clear never loses a coincident increment
module sat_counter #(
  parameter int W = 16
) (
  input logic clk,
  input logic resetn,
  input logic clr,
  input logic inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    count_d = clr ? (inc ? W'(1) : '0) : (inc && count_q != '1) ? count_q + W'(1) : count_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with saturating match counter
module seq_detector_prog import seq_det_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int DEF_LEN = 4,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1010),
  parameter logic DEF_OVERLAP = 1'b1
) (
  input logic clk,
  input logic resetn,
  seq_detector_prog_if.slave bus
);
  cfg_t cfg_q, cfg_d;
  logic [MAX_LEN-1:0] history_q, history_d, next_history;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic dout_q, dout_d, err_q, err_d, cfg_ok, load, match;
  always_comb begin
    next_history = {history_q[MAX_LEN-2:0], bus.din};
    cfg_ok = bus.cfg_len != '0 && bus.cfg_len <= LEN_W'(MAX_LEN);
    load = bus.cfg_load && cfg_ok;
    match = !load && bus.din_valid && (fill_q + LEN_W'(1) >= cfg_q.len)
      && ((next_history ^ cfg_q.pattern) & len_mask(cfg_q.len)) == '0;
    cfg_d = load ? cfg_t'{pattern: bus.cfg_pattern, len: bus.cfg_len, overlap: bus.cfg_overlap} : cfg_q;
    history_d = load ? '0 : bus.din_valid ? next_history : history_q;
    fill_d = load ? '0 : (match && !cfg_q.overlap) ? '0 :
      !bus.din_valid ? fill_q : (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    dout_d = match;
    err_d = bus.cfg_load && !cfg_ok;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q <= cfg_t'{pattern: DEF_PATTERN, len: LEN_W'(DEF_LEN), overlap: DEF_OVERLAP};
      history_q <= '0;
      fill_q <= '0;
      dout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      history_q <= history_d;
      fill_q <= fill_d;
      dout_q <= dout_d;
      err_q <= err_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .resetn(resetn),
    .clr(bus.cnt_clr),
    .inc(dout_d),
    .count(bus.match_count)
  );
  assign bus.dout = dout_q;
  assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed and random checks of the detector against a bit-queue model
module tb_seq_detector_prog;
  import seq_det_pkg::*;
  logic clk = 0, resetn = 0;
  logic din = 0, din_valid = 0, cfg_load = 0, cfg_overlap = 0, cnt_clr = 0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seq_detector_prog_if #(.CNT_W(16)) b16 ();
  seq_detector_prog_if #(.CNT_W(2)) b2 ();
  assign b16.din = din;
  assign b16.din_valid = din_valid;
  assign b16.cfg_load = cfg_load;
  assign b16.cfg_pattern = cfg_pattern;
  assign b16.cfg_len = cfg_len;
  assign b16.cfg_overlap = cfg_overlap;
  assign b16.cnt_clr = cnt_clr;
  assign b2.din = din;
  assign b2.din_valid = din_valid;
  assign b2.cfg_load = cfg_load;
  assign b2.cfg_pattern = cfg_pattern;
  assign b2.cfg_len = cfg_len;
  assign b2.cfg_overlap = cfg_overlap;
  assign b2.cnt_clr = cnt_clr;
  seq_detector_prog #(.CNT_W(16)) dut16 (.clk(clk), .resetn(resetn), .bus(b16.slave));
  seq_detector_prog #(.CNT_W(2)) dut2 (.clk(clk), .resetn(resetn), .bus(b2.slave));
  logic [MAX_LEN-1:0] m_pat;
  int m_len, e_c16, e_c2;
  bit m_ov, e_dout, e_err, hit;
  bit q[$];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pat = MAX_LEN'('b1010);
      m_len = 4;
      m_ov = 1;
      q.delete();
      e_c16 = 0;
      e_c2 = 0;
      e_dout = 0;
      e_err = 0;
    end else begin
      hit = 0;
      e_err = 0;
      if (cfg_load && cfg_len >= 1 && cfg_len <= MAX_LEN) begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ov = cfg_overlap;
        q.delete();
      end else begin
        e_err = cfg_load;
        if (din_valid) begin
          q.push_back(din);
          if (q.size() > MAX_LEN) void'(q.pop_front());
          if (q.size() >= m_len) begin
            hit = 1;
            for (int i = 0; i < m_len; i++) if (q[q.size()-1-i] != m_pat[i]) hit = 0;
          end
          if (hit && !m_ov) q.delete();
        end
      end
      e_dout = hit;
      e_c16 = cnt_clr ? int'(hit) : (hit && e_c16 < 65535) ? e_c16 + 1 : e_c16;
      e_c2 = cnt_clr ? int'(hit) : (hit && e_c2 < 3) ? e_c2 + 1 : e_c2;
    end
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (resetn) begin
      check("dout", int'(b16.dout), int'(e_dout));
      check("dout_w2", int'(b2.dout), int'(e_dout));
      check("cfg_err", int'(b16.cfg_err), int'(e_err));
      check("count", int'(b16.match_count), e_c16);
      check("count_w2", int'(b2.match_count), e_c2);
    end
  end
  task automatic drive(input logic d, input logic v, input logic ld, input logic [LEN_W-1:0] ln,
                       input logic [MAX_LEN-1:0] pt, input logic ov, input logic clr);
    @(negedge clk);
    din = d;
    din_valid = v;
    cfg_load = ld;
    cfg_len = ln;
    cfg_pattern = pt;
    cfg_overlap = ov;
    cnt_clr = clr;
  endtask
  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0);
  endtask
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i] == "1", 1, 0, '0, '0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    din_valid = 0;
    cfg_load = 0;
    cnt_clr = 0;
    #1;
    check("rst_dout", int'(b16.dout), 0);
    check("rst_count", int'(b16.match_count), 0);
    check("rst_err", int'(b16.cfg_err), 0);
    @(negedge clk);
    resetn = 1;
  endtask
  initial begin
    do_reset();
    send("1010");
    idle();
    check("t1_first_pulse", int'(b16.dout), 1);
    send("10");
    idle();
    check("t1_second_pulse", int'(b16.dout), 1);
    check("t1_count", int'(b16.match_count), 2);
    do_reset();
    drive(0, 0, 1, LEN_W'(3), MAX_LEN'('b110), 0, 0);
    send("11011010");
    idle();
    check("t2_count", int'(b16.match_count), 2);
    do_reset();
    send("10");
    repeat (5) idle();
    send("10");
    idle();
    check("t3_pulse", int'(b16.dout), 1);
    check("t3_count", int'(b16.match_count), 1);
    do_reset();
    drive(0, 0, 1, LEN_W'(0), '1, 0, 0);
    idle();
    check("t4_err_len0", int'(b16.cfg_err), 1);
    drive(0, 0, 1, LEN_W'(9), '1, 0, 0);
    idle();
    check("t4_err_len9", int'(b16.cfg_err), 1);
    send("1010");
    idle();
    check("t4_default_kept", int'(b16.match_count), 1);
    do_reset();
    send("101010101010");
    idle();
    check("t5_sat_w2", int'(b2.match_count), 3);
    check("t5_count", int'(b16.match_count), 5);
    send("1");
    drive(0, 1, 0, '0, '0, 0, 1);
    idle();
    check("t5_clr_inc_w2", int'(b2.match_count), 1);
    check("t5_clr_inc", int'(b16.match_count), 1);
    drive(0, 0, 0, '0, '0, 0, 1);
    idle();
    check("t5_clr_only", int'(b16.match_count), 0);
    do_reset();
    send("101");
    do_reset();
    send("0");
    idle();
    check("t6_no_pulse", int'(b16.dout), 0);
    drive(1, 1, 1, LEN_W'(4), MAX_LEN'('b1010), 1, 0);
    send("010");
    idle();
    check("t6_load_discard", int'(b16.match_count), 0);
    do_reset();
    repeat (3000) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
            LEN_W'($urandom_range(0, 15)), MAX_LEN'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0);
    end
    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
